// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit serializer.
//   fsk_state_e  : framing FSM states (3-bit encoding)
//   *_DIV_DEF    : default divider ratios for bit period and tone clocks
//   IDLE_MARK    : line level while no frame is being sent
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } fsk_state_e;

    localparam int BIT_DIV_DEF = 1000;
    localparam int F0_DIV_DEF  = 40;
    localparam int F1_DIV_DEF  = 20;

    localparam logic IDLE_MARK = 1'b1;

endpackage

// File: rtl/fsk_clk_div.sv
// Free-running divide-by-DIV counter with a 50% square wave.
//   clk, rst : system clock, asynchronous active-high reset
//   cnt      : current count, 0..DIV-1 (0 during reset)
//   wrap     : high on the cycle where cnt == DIV-1
//   sq       : registered square wave, high while cnt < DIV/2 (low during reset)
// DIV must be even and >= 2.
module fsk_clk_div #(
    parameter  int DIV   = 4,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;

    assign wrap = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        // Decode from the next count so sq lines up with cnt rather than lagging it.
        sq_d  = (cnt_d < CNT_W'(DIV / 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign cnt = cnt_q;
    assign sq  = sq_q;

endmodule

// File: rtl/fsk_tx_serializer.sv
// FSK transmit serializer: accepts parallel words over valid/ready and sends
// them as start + data (LSB first) + [parity] + stop on serial_bit, aligned to a
// free-running bit timer. Also provides the bit-period strobe and both tone clocks.
//   clk, rst    : system clock, asynchronous active-high reset
//   in_data     : word to send, captured when in_valid && in_ready
//   in_valid    : in_data valid
//   in_ready    : high only while idle (and out of reset)
//   serial_bit  : framed bit stream, idles at mark (1)
//   bit_clk     : high for the first BIT_DIV/2 cycles of each bit period
//   clk_f0      : tone clock for a 0 bit, period F0_DIV
//   clk_f1      : tone clock for a 1 bit, period F1_DIV
//   busy        : frame in progress (state != IDLE)
//   frame_done  : one-cycle pulse on the last cycle of the stop bit
// Build option: define FSK_TX_PARITY_EN to append an even-parity bit after the data.
module fsk_tx_serializer
    import fsk_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = BIT_DIV_DEF,
    parameter int F0_DIV  = F0_DIV_DEF,
    parameter int F1_DIV  = F1_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_bit,
    output logic              bit_clk,
    output logic              clk_f0,
    output logic              clk_f1,
    output logic              busy,
    output logic              frame_done
);

    localparam int DCNT_W = $clog2(DATA_W + 1);

    // Only the wrap and square outputs are needed here; the counts stay inside the dividers.
    logic [$clog2(BIT_DIV)-1:0] bit_cnt_unused;
    logic [$clog2(F0_DIV)-1:0]  f0_cnt_unused;
    logic [$clog2(F1_DIV)-1:0]  f1_cnt_unused;
    logic                       f0_wrap_unused;
    logic                       f1_wrap_unused;
    logic                       bit_wrap;

    fsk_clk_div #(.DIV(BIT_DIV)) u_bit_div (
        .clk  (clk),
        .rst  (rst),
        .cnt  (bit_cnt_unused),
        .wrap (bit_wrap),
        .sq   (bit_clk)
    );

    fsk_clk_div #(.DIV(F0_DIV)) u_f0_div (
        .clk  (clk),
        .rst  (rst),
        .cnt  (f0_cnt_unused),
        .wrap (f0_wrap_unused),
        .sq   (clk_f0)
    );

    fsk_clk_div #(.DIV(F1_DIV)) u_f1_div (
        .clk  (clk),
        .rst  (rst),
        .cnt  (f1_cnt_unused),
        .wrap (f1_wrap_unused),
        .sq   (clk_f1)
    );

    fsk_state_e        state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              serial_bit_q, serial_bit_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
`ifdef FSK_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              xfer;

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        serial_bit_d = serial_bit_q;
        shreg_d      = shreg_q;
`ifdef FSK_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Always pass through WAIT, even on a boundary cycle, so a start bit
                // never begins mid-period and back-to-back frames keep a mark gap.
                if (xfer) begin
                    state_d = WAIT;
                    shreg_d = in_data;
`ifdef FSK_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            WAIT: begin
                if (bit_wrap) begin
                    state_d      = START;
                    serial_bit_d = 1'b0;
                end
            end
            START: begin
                if (bit_wrap) begin
                    state_d      = DATA;
                    serial_bit_d = shreg_q[0];
                    shreg_d      = shreg_q >> 1;
                    dcnt_d       = DCNT_W'(1);
                end
            end
            DATA: begin
                // dcnt counts data bits already placed on the line; it stops at DATA_W.
                if (bit_wrap) begin
                    if (dcnt_q == DCNT_W'(DATA_W)) begin
`ifdef FSK_TX_PARITY_EN
                        state_d      = PARITY;
                        serial_bit_d = par_q;
`else
                        state_d      = STOP;
                        serial_bit_d = IDLE_MARK;
`endif
                    end else begin
                        serial_bit_d = shreg_q[0];
                        shreg_d      = shreg_q >> 1;
                        dcnt_d       = dcnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef FSK_TX_PARITY_EN
                if (bit_wrap) begin
                    state_d      = STOP;
                    serial_bit_d = IDLE_MARK;
                end
`else
                state_d      = IDLE;
                serial_bit_d = IDLE_MARK;
`endif
            end
            STOP: begin
                if (bit_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                serial_bit_d = IDLE_MARK;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dcnt_q       <= '0;
            serial_bit_q <= IDLE_MARK;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            serial_bit_q <= serial_bit_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef FSK_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign in_ready   = in_ready_q;
    assign serial_bit = serial_bit_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_wrap;

endmodule

// File: tb/tb_fsk_tx_serializer.sv
module tb_fsk_tx_serializer;

    localparam int DATA_W  = 8;
    localparam int BIT_DIV = 8;
    localparam int F0_DIV  = 4;
    localparam int F1_DIV  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              serial_bit;
    logic              bit_clk;
    logic              clk_f0;
    logic              clk_f1;
    logic              busy;
    logic              frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;   // bits[0] is the start bit, transmitted first
        int          len;
    } vec_t;

    vec_t tbl [6];

    fsk_tx_serializer #(
        .DATA_W  (DATA_W),
        .BIT_DIV (BIT_DIV),
        .F0_DIV  (F0_DIV),
        .F1_DIV  (F1_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_bit (serial_bit),
        .bit_clk    (bit_clk),
        .clk_f0     (clk_f0),
        .clk_f1     (clk_f1),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Samples 32 consecutive cycles starting at the current negedge.
    task automatic sample32(output logic [31:0] bc, output logic [31:0] f0, output logic [31:0] f1,
                            output logic [31:0] ser, output logic [31:0] bsy, output logic [31:0] rdy);
        for (int i = 0; i < 32; i++) begin
            bc[i]  = bit_clk;
            f0[i]  = clk_f0;
            f1[i]  = clk_f1;
            ser[i] = serial_bit;
            bsy[i] = busy;
            rdy[i] = in_ready;
            @(negedge clk);
        end
    endtask

    // Offers d, waits for acceptance, then waits for the start bit. Returns with the
    // current negedge on cycle 0 of the start bit.
    task automatic send_byte(input string tag, input logic [7:0] d, input bit hold,
                             input logic [7:0] nxt, output int lat);
        int w;
        in_data  = d;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 12 * BIT_DIV) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept"}, in_ready, 1);
        @(negedge clk);
        if (hold) in_data = nxt;
        else in_valid = 1'b0;
        chk({tag, " busy after accept"}, busy, 1);
        chk({tag, " ready drops"}, in_ready, 0);
        lat = 1;
        while (serial_bit !== 1'b0 && lat < 3 * BIT_DIV) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " start latency in 2..9"}, (lat >= 2 && lat <= BIT_DIV + 1), 1);
    endtask

    // Checks a whole frame from cycle 0 of the start bit; returns one cycle past the stop bit.
    task automatic run_frame(input string tag, input logic [10:0] bits, input int len);
        logic [7:0] ser;
        int bc_bad, rdy_hi, fd_cnt, fd_pos;
        bc_bad = 0; rdy_hi = 0; fd_cnt = 0; fd_pos = -1;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < BIT_DIV; c++) begin
                ser[c] = serial_bit;
                if (bit_clk !== (c < BIT_DIV / 2)) bc_bad++;
                if (in_ready !== 1'b0) rdy_hi++;
                if (frame_done === 1'b1) begin
                    fd_cnt++;
                    fd_pos = i * BIT_DIV + c;
                end
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d", tag, i), ser, bits[i] ? 8'hFF : 8'h00);
        end
        chk({tag, " bit_clk aligned to bits"}, bc_bad, 0);
        chk({tag, " in_ready low in frame"}, rdy_hi, 0);
        chk({tag, " frame_done pulse count"}, fd_cnt, 1);
        chk({tag, " frame_done position"}, fd_pos, len * BIT_DIV - 1);
        chk({tag, " busy after frame"}, busy, 0);
        chk({tag, " frame_done after frame"}, frame_done, 0);
        chk({tag, " mark after frame"}, serial_bit, 1);
        chk({tag, " ready after frame"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] bc, f0, f1, ser, bsy, rdy;
        int lat, gap;

`ifdef FSK_TX_PARITY_EN
        tbl[0] = '{8'hA5, 11'b1_0_1010_0101_0, 11};
        tbl[1] = '{8'h01, 11'b1_1_0000_0001_0, 11};
        tbl[2] = '{8'h80, 11'b1_1_1000_0000_0, 11};
        tbl[3] = '{8'h00, 11'b1_0_0000_0000_0, 11};
        tbl[4] = '{8'hFF, 11'b1_0_1111_1111_0, 11};
        tbl[5] = '{8'h3C, 11'b1_0_0011_1100_0, 11};
`else
        tbl[0] = '{8'hA5, 11'b0_1_1010_0101_0, 10};
        tbl[1] = '{8'h01, 11'b0_1_0000_0001_0, 10};
        tbl[2] = '{8'h80, 11'b0_1_1000_0000_0, 10};
        tbl[3] = '{8'h00, 11'b0_1_0000_0000_0, 10};
        tbl[4] = '{8'hFF, 11'b0_1_1111_1111_0, 10};
        tbl[5] = '{8'h3C, 11'b0_1_0011_1100_0, 10};
`endif

        // Reset state
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (5) @(negedge clk);
        chk("reset serial_bit", serial_bit, 1);
        chk("reset bit_clk", bit_clk, 0);
        chk("reset clk_f0", clk_f0, 0);
        chk("reset clk_f1", clk_f1, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release in_ready", in_ready, 1);
        chk("release busy", busy, 0);

        // Free-running timers; sample 0 is the first cycle after release (counts at 1)
        sample32(bc, f0, f1, ser, bsy, rdy);
        chk("free bit_clk pattern", bc, 32'h87878787);
        chk("free clk_f0 pattern", f0, 32'h99999999);
        chk("free clk_f1 pattern", f1, 32'hAAAAAAAA);
        chk("free idle mark", ser, 32'hFFFFFFFF);

        // Table-driven single frames
        for (int k = 0; k < 3; k++) begin
            send_byte($sformatf("tbl%0d", k), tbl[k].data, 1'b0, 8'h00, lat);
            run_frame($sformatf("tbl%0d(%02h)", k, tbl[k].data), tbl[k].bits, tbl[k].len);
        end

        // Back-to-back with in_valid held: 0x00 then 0xFF
        send_byte("b2b first", tbl[3].data, 1'b1, tbl[4].data, lat);
        run_frame("b2b 00", tbl[3].bits, tbl[3].len);
        gap = 0;
        while (serial_bit === 1'b1 && gap < 3 * BIT_DIV) begin
            gap++;
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("b2b mark gap cycles", gap, BIT_DIV);
        run_frame("b2b FF", tbl[4].bits, tbl[4].len);

        // Async reset during data bit 3 of 0x3C
        send_byte("rst frame", tbl[5].data, 1'b0, 8'h00, lat);
        repeat (4 * BIT_DIV + 2) @(negedge clk);
        chk("pre-reset bit_clk", bit_clk, 1);
        chk("pre-reset busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst serial_bit", serial_bit, 1);
        chk("async rst bit_clk", bit_clk, 0);
        chk("async rst busy", busy, 0);
        chk("async rst in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sample32(bc, f0, f1, ser, bsy, rdy);
        chk("post-rst bit_clk restart", bc, 32'h87878787);
        chk("post-rst clk_f0 restart", f0, 32'h99999999);
        chk("post-rst no residual bits", ser, 32'hFFFFFFFF);
        chk("post-rst busy", bsy, 32'h0);
        chk("post-rst in_ready", rdy, 32'hFFFFFFFF);

        send_byte("after rst", tbl[0].data, 1'b0, 8'h00, lat);
        run_frame("after rst A5", tbl[0].bits, tbl[0].len);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
